// File: rtl/v810_data_bus_resizer.sv
// v810_data_bus_resizer
// Bus-width and wait-state emulator between the V810 external bus and a
// 32-bit memory array. It inserts WS wait cycles per access, drives READYn,
// requests 16-bit sizing through SZRQn when DW==16, and steers data lanes.
//
// Build option:
//   DBR_TRISTATE_EN defined   : CTLR_DI is high-Z while the block is idle
//                               (shared read-data wire).
//   DBR_TRISTATE_EN undefined : CTLR_DI drives zero while idle
//                               (OR-combined read fabrics).
module v810_data_bus_resizer (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic [31:0] WS,
    input  logic [31:0] DW,
    input  logic        CTLR_DAn,
    input  logic [3:0]  CTLR_BEn,
    output logic        CTLR_READYn,
    output logic        CTLR_SZRQn,
    output logic [31:0] CTLR_DI,
    input  logic [31:0] CTLR_DO,
    input  logic        MEM_nCE,
    output logic [31:0] MEM_DI,
    input  logic [31:0] MEM_DO
);

    logic        active;
    logic        narrow;
    logic        at_ws;
    logic        low_half_sel;
    logic [31:0] wcnt_reg;
    logic [31:0] wcnt_next;
    logic [31:0] rd_data;

    // RESn is folded into the access qualifier so READYn/SZRQn and the data
    // steering stay idle for the whole time reset is held, not just at the edge.
    assign active       = ~CTLR_DAn & ~MEM_nCE & RESn;
    assign narrow       = (DW == 32'd16);
    assign at_ws        = (wcnt_reg == WS);
    assign low_half_sel = ~(CTLR_BEn[0] & CTLR_BEn[1]);

    assign CTLR_READYn  = ~(active & at_ws);
    assign CTLR_SZRQn   = ~(active & narrow);

    // Wait counter next state: clear when idle or on the ready cycle,
    // count up to WS otherwise; a WS lowered below the count just parks it.
    always_comb begin
        wcnt_next = wcnt_reg;
        if (!active) begin
            wcnt_next = 32'd0;
        end else if (CE) begin
            if (at_ws) begin
                wcnt_next = 32'd0;
            end else if (wcnt_reg < WS) begin
                wcnt_next = wcnt_reg + 32'd1;
            end
        end
    end

    // Wait counter register.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            wcnt_reg <= 32'd0;
        end else begin
            wcnt_reg <= wcnt_next;
        end
    end

    // Byte-lane steering. In narrow mode the controller only looks at D[15:0]:
    // reads fetch the upper memory half there when neither low byte is enabled,
    // writes replicate the low half onto both memory halves so the byte enables
    // pick the half that is really written.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 2) begin : g_low
                assign rd_data[8*gi +: 8] = (narrow && !low_half_sel) ?
                                            MEM_DO[8*gi+16 +: 8] : MEM_DO[8*gi +: 8];
            end else begin : g_high
                assign rd_data[8*gi +: 8] = MEM_DO[8*gi +: 8];
            end
            assign MEM_DI[8*gi +: 8] = (active && narrow) ?
                                       CTLR_DO[8*(gi%2) +: 8] : CTLR_DO[8*gi +: 8];
        end
    endgenerate

`ifdef DBR_TRISTATE_EN
    assign CTLR_DI = active ? rd_data : 32'hzzzz_zzzz;
`else
    assign CTLR_DI = active ? rd_data : 32'h0000_0000;
`endif

endmodule

// File: tb/tb_v810_data_bus_resizer.sv
// Self-checking bench for v810_data_bus_resizer: directed scenarios plus a
// randomized run, all compared against a bus-level reference model.
module tb_v810_data_bus_resizer;

    logic        CLK = 1'b0;
    logic        RESn;
    logic        CE;
    logic [31:0] WS;
    logic [31:0] DW;
    logic        CTLR_DAn;
    logic [3:0]  CTLR_BEn;
    logic        CTLR_READYn;
    logic        CTLR_SZRQn;
    logic [31:0] CTLR_DI;
    logic [31:0] CTLR_DO;
    logic        MEM_nCE;
    logic [31:0] MEM_DI;
    logic [31:0] MEM_DO;

    int vectors = 0;
    int errors  = 0;

    v810_data_bus_resizer dut (
        .CLK(CLK), .RESn(RESn), .CE(CE), .WS(WS), .DW(DW),
        .CTLR_DAn(CTLR_DAn), .CTLR_BEn(CTLR_BEn),
        .CTLR_READYn(CTLR_READYn), .CTLR_SZRQn(CTLR_SZRQn),
        .CTLR_DI(CTLR_DI), .CTLR_DO(CTLR_DO),
        .MEM_nCE(MEM_nCE), .MEM_DI(MEM_DI), .MEM_DO(MEM_DO)
    );

    always #5 CLK = ~CLK;

`ifdef DBR_TRISTATE_EN
    localparam logic [31:0] IDLE_DI = 32'hzzzz_zzzz;
`else
    localparam logic [31:0] IDLE_DI = 32'h0000_0000;
`endif

    // Reference: {READYn, SZRQn, CTLR_DI, MEM_DI} from bus-level rules.
    function automatic logic [65:0] model(input bit act, input bit dw16, input bit rdy,
                                          input logic [3:0] ben, input logic [31:0] mdo,
                                          input logic [31:0] cdo);
        logic [31:0] di, mi;
        logic [15:0] hi, lo;
        hi = mdo[31:16];
        if (!act) begin
            di = IDLE_DI;
            mi = cdo;
        end else if (dw16) begin
            lo = (ben[1:0] != 2'b11) ? mdo[15:0] : hi;
            di = {hi, lo};
            mi = {cdo[15:0], cdo[15:0]};
        end else begin
            di = mdo;
            mi = cdo;
        end
        return {~(act & rdy), ~(act & dw16), di, mi};
    endfunction

    task automatic idle_cycle();
        CTLR_DAn = 1'b1;
        CE       = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        logic [65:0] got, exp;
        RESn = 1'b0; CE = 1'b1; WS = 32'd0; DW = 32'd32; CTLR_DAn = 1'b1;
        CTLR_BEn = 4'h0; CTLR_DO = 32'hCAFE_F00D; MEM_nCE = 1'b0; MEM_DO = 32'h1111_2222;
        @(negedge CLK);
        got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
        exp = model(0, 0, 0, CTLR_BEn, MEM_DO, CTLR_DO);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_idle: got %h required %h", got, exp);
        end
        // DAn low while reset held: still idle even though WS=0.
        CTLR_DAn = 1'b0; DW = 32'd16;
        @(negedge CLK);
        got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
        exp = model(0, 1, 1, CTLR_BEn, MEM_DO, CTLR_DO);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_held_dan_low: got %h required %h", got, exp);
        end
        @(posedge CLK); #1;
        CTLR_DAn = 1'b1;
        RESn = 1'b1;
        idle_cycle();
        $display("reset: checked idle outputs under reset");
    endtask

    task automatic test_ws0_read32();
        logic [65:0] got, exp;
        idle_cycle();
        WS = 32'd0; DW = 32'd32; CTLR_BEn = 4'h0; MEM_DO = 32'h1234_5678; CTLR_DO = 32'h0BAD_0BAD;
        CTLR_DAn = 1'b0;
        @(negedge CLK);
        got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
        exp = {1'b0, 1'b1, 32'h1234_5678, 32'h0BAD_0BAD};
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ws0_read32: got %h required %h", got, exp);
        end
        @(posedge CLK); #1;
        CTLR_DAn = 1'b1;
        @(negedge CLK);
        got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
        exp = model(0, 0, 0, CTLR_BEn, MEM_DO, CTLR_DO);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ws0_after: got %h required %h", got, exp);
        end
        @(posedge CLK); #1;
        $display("ws0_read32: di=%h readyn=%b", 32'h1234_5678, 1'b0);
    endtask

    task automatic test_narrow_read();
        logic [65:0] got, exp;
        logic [3:0]  ben_tab [2];
        logic [15:0] lo_tab [2];
        ben_tab[0] = 4'b1100; lo_tab[0] = 16'h5555;
        ben_tab[1] = 4'b0011; lo_tab[1] = 16'hAAAA;
        idle_cycle();
        WS = 32'd1; DW = 32'd16; MEM_DO = 32'hAAAA_5555; CTLR_DO = 32'h0;
        CTLR_DAn = 1'b0;
        for (int a = 0; a < 2; a++) begin
            CTLR_BEn = ben_tab[a];
            for (int k = 0; k < 2; k++) begin
                @(negedge CLK);
                got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI};
                exp = {32'b0, (k != 1), 1'b0, 16'hAAAA, lo_tab[a]};
                vectors++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL narrow_read ben=%b k=%0d: got %h required %h",
                             ben_tab[a], k, got, exp);
                end
                @(posedge CLK); #1;
            end
            $display("narrow_read: ben=%b lo=%h", ben_tab[a], lo_tab[a]);
        end
        idle_cycle();
    endtask

    task automatic test_narrow_write();
        logic [31:0] got;
        idle_cycle();
        WS = 32'd0; DW = 32'd16; CTLR_BEn = 4'b1100; CTLR_DO = 32'h0000_BEEF;
        CTLR_DAn = 1'b0;
        @(negedge CLK);
        got = MEM_DI;
        vectors++;
        if (got !== 32'hBEEF_BEEF) begin
            errors++;
            $display("FAIL narrow_write: got %h required %h", got, 32'hBEEF_BEEF);
        end
        @(posedge CLK); #1;
        idle_cycle();
        $display("narrow_write: mem_di=%h", got);
    endtask

    task automatic test_inert();
        logic [65:0] got, exp;
        idle_cycle();
        WS = 32'd0; DW = 32'd16; MEM_nCE = 1'b1; CTLR_DAn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            MEM_DO = $urandom; CTLR_DO = $urandom; CTLR_BEn = 4'($urandom);
            @(negedge CLK);
            got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
            exp = model(0, 1, 1, CTLR_BEn, MEM_DO, CTLR_DO);
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL inert k=%0d: got %h required %h", k, got, exp);
            end
            @(posedge CLK); #1;
        end
        MEM_nCE = 1'b0;
        idle_cycle();
        $display("inert: 5 cycles with MEM_nCE high");
    endtask

    task automatic test_abort();
        logic [65:0] got, exp;
        idle_cycle();
        WS = 32'd4; DW = 32'd32; CTLR_BEn = 4'h0; MEM_DO = 32'h5A5A_A5A5; CTLR_DO = 32'h0;
        // Aborted after 2 cycles, then a full fresh access.
        for (int k = 0; k < 8; k++) begin
            CTLR_DAn = (k == 2);
            @(negedge CLK);
            got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
            exp = model(k != 2, 0, k == 7, CTLR_BEn, MEM_DO, CTLR_DO);
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort k=%0d: got %h required %h", k, got, exp);
            end
            @(posedge CLK); #1;
        end
        idle_cycle();
        $display("abort: aborted access then full 4-wait access");
    endtask

    task automatic test_reset_mid_access();
        logic [65:0] got, exp;
        idle_cycle();
        WS = 32'd3; DW = 32'd32; CTLR_BEn = 4'h0; MEM_DO = 32'h0F0F_F0F0; CTLR_DO = 32'h0;
        CTLR_DAn = 1'b0;
        // Two waits, one cycle in reset, then a fresh access with DAn still low.
        for (int k = 0; k < 7; k++) begin
            RESn = (k != 2);
            @(negedge CLK);
            got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
            exp = model(k != 2, 0, k == 6, CTLR_BEn, MEM_DO, CTLR_DO);
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid k=%0d: got %h required %h", k, got, exp);
            end
            @(posedge CLK); #1;
        end
        RESn = 1'b1;
        idle_cycle();
        $display("reset_mid_access: fresh access waited 3 cycles");
    endtask

    // Random back-to-back accesses with random CE gaps: each access needs WS
    // enabled edges before READYn, and READYn is consumed on an enabled edge.
    task automatic test_random_accesses();
        logic [65:0] got, exp;
        int ws, nb, n_en, done, guard;
        bit dw16, rdy;
        for (int t = 0; t < 25; t++) begin
            idle_cycle();
            ws = $urandom_range(0, 4);
            nb = $urandom_range(1, 3);
            WS = ws;
            if ($urandom_range(0, 1) == 1) DW = 32'd16;
            else begin
                DW = $urandom;
                if (DW == 32'd16) DW = 32'd32;
            end
            dw16 = (DW == 32'd16);
            CTLR_BEn = 4'($urandom);
            CTLR_DAn = 1'b0;
            n_en = 0; done = 0; guard = 0;
            while (done < nb && guard < 200) begin
                CE = ($urandom_range(0, 3) != 0);
                MEM_DO = $urandom; CTLR_DO = $urandom;
                rdy = ((n_en % (ws + 1)) == ws);
                @(negedge CLK);
                got = {CTLR_READYn, CTLR_SZRQn, CTLR_DI, MEM_DI};
                exp = model(1, dw16, rdy, CTLR_BEn, MEM_DO, CTLR_DO);
                vectors++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random t=%0d cyc=%0d: got %h required %h", t, guard, got, exp);
                end
                if (CE) begin
                    n_en++;
                    if (rdy) done++;
                end
                guard++;
                @(posedge CLK); #1;
            end
            vectors++;
            if (done != nb) begin
                errors++;
                $display("FAIL random_timeout t=%0d: got %0d readies required %0d", t, done, nb);
            end
            $display("random t=%0d: ws=%0d dw=%0d ben=%b accesses=%0d cycles=%0d",
                     t, ws, DW, CTLR_BEn, nb, guard);
        end
        idle_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ws0_read32();
        test_narrow_read();
        test_narrow_write();
        test_inert();
        test_abort();
        test_reset_mid_access();
        test_random_accesses();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/v810_data_bus_resizer.md
# v810_data_bus_resizer

Bus-width and wait-state emulator between the V810 memory access unit's external bus (controller side) and a 32-bit-wide memory array (memory side). The width (32 or 16 bit) and number of wait states are runtime-selectable. For each bus cycle it inserts WS wait cycles, asserts the controller's READYn, requests 16-bit sizing via SZRQn when configured narrow, and steers data lanes. It sits in the system bus fabric in front of each RAM/ROM block.

## Interface
Parameters: none. Widths and wait counts are run-time inputs.

Ports:
- CLK  in  1  system clock. All state changes on rising edge.
- RESn  in  1  reset, asynchronous, active-low.
- CE  in  1  clock enable. State advances only on edges with CE=1.
- WS  in  32  wait states per access, unsigned integer. Held stable during an access.
- DW  in  32  emulated data width. 16 selects 16-bit mode; any other value selects 32-bit mode.
- CTLR_DAn  in  1  data strobe from controller, active-low. Low for the whole access.
- CTLR_BEn  in  4  byte enables, active-low. Bit i corresponds to lane D[8i+7:8i].
- CTLR_READYn  out  1  access-complete, active-low. Wired-AND capable.
- CTLR_SZRQn  out  1  16-bit size request, active-low. Wired-AND capable.
- CTLR_DI  out  32  read data to controller.
- CTLR_DO  in  32  write data from controller.
- MEM_nCE  in  1  device select, active-low. When high the block is inert.
- MEM_DI  out  32  write data to memory.
- MEM_DO  in  32  read data from memory.

## Operation
- Active = ~CTLR_DAn & ~MEM_nCE.
- Wait counter `wcnt`:
  - Unsigned 32-bit register, reset 0.
  - Cleared whenever Active=0.
  - While Active, increments on each CE edge until it equals WS.
  - On the CE edge where READYn is low, it returns to 0 so back-to-back accesses (DAn held low) each insert WS waits again.
- CTLR_READYn = ~(Active & wcnt==WS). Combinational, so WS=0 gives ready in the first cycle of DAn low.
- CTLR_SZRQn = ~(Active & DW==16).
- Read path, 32-bit mode: CTLR_DI = MEM_DO.
- Read path, 16-bit mode:
  - If either of CTLR_BEn[1:0] is low, CTLR_DI[15:0] = MEM_DO[15:0].
  - Otherwise CTLR_DI[15:0] = MEM_DO[31:16].
  - CTLR_DI[31:16] = MEM_DO[31:16] (don't-care to the controller).
- Write path, 32-bit mode: MEM_DI = CTLR_DO.
- Write path, 16-bit mode: MEM_DI = {CTLR_DO[15:0], CTLR_DO[15:0]}. The memory's own byte enables (CTLR_BEn) select the half actually written.
- Inactive (Active=0): READYn=1, SZRQn=1, CTLR_DI per Configuration, MEM_DI = CTLR_DO.
- Z/X bits on MEM_DO propagate unchanged to CTLR_DI.

## Timing
- Reset values: wcnt=0; CTLR_READYn=1; CTLR_SZRQn=1; CTLR_DI idle value; MEM_DI = CTLR_DO.
- Access latency: READYn goes low WS cycles after the first cycle with DAn low, and stays low exactly one CE cycle if DAn stays low.
- DAn rising before READYn (aborted access): wcnt clears; no READYn pulse.
- CE=0: wcnt frozen; outputs still follow combinational equations.
- WS changed mid-access: new value compared immediately. If wcnt > WS, no READYn until DAn deasserts. Behaviour is legal but unsupported.
- RESn asserted mid-access: wcnt→0 at once; READYn/SZRQn high while RESn low.
- MEM_nCE rising mid-access: treated as Active=0 (wcnt clears).

## Configuration
- DBR_TRISTATE_EN defined: CTLR_DI is high-Z while Active=0, allowing several resizers on one read-data wire.
- DBR_TRISTATE_EN undefined: CTLR_DI drives 32'h0 while Active=0, suitable for OR-combined FPGA fabrics.
- The READYn/SZRQn idle level is 1 in both builds.

## Test plan
- DW=32, WS=0, MEM_DO=32'h12345678, DAn low one cycle → READYn low in that same cycle; CTLR_DI=32'h12345678; SZRQn=1.
- DW=32, WS=2, DAn held low → READYn high for cycles 0 and 1, low in cycle 2; wcnt back to 0; a second back-to-back access again waits 2 cycles.
- DW=16, WS=1, MEM_DO=32'hAAAA5555:
  - BEn=4'b1100 → CTLR_DI[15:0]=16'h5555, READYn low in cycle 1.
  - BEn=4'b0011 → CTLR_DI[15:0]=16'hAAAA.
  - SZRQn=0 throughout.
- DW=16 write, CTLR_DO=32'h0000BEEF → MEM_DI=32'hBEEFBEEF.
- MEM_nCE=1 with DAn low for 5 cycles → READYn=1, SZRQn=1, CTLR_DI idle value.
- RESn pulsed low at WS=3 after 2 wait cycles → READYn stays 1; after release, a fresh access waits the full 3 cycles.
